// File: rtl/multi_ff_bank.sv
// Run-time configurable D/T/JK/SR flip-flop bank with enable,
// registered complementary outputs, change flags and sticky SR error.
module multi_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] toggled,
    output logic             sr_err
);

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] q_n_q, q_n_d;
    logic [WIDTH-1:0] toggled_q, toggled_d;
    logic             sr_err_q, sr_err_d;
    logic [WIDTH-1:0] q_next;
    logic             sr_set;

    always_comb begin
        q_next = q_q;
        unique case (mode)
            MODE_D:  q_next = a;
            MODE_T:  q_next = q_q ^ a;
            MODE_JK: q_next = (a & ~q_q) | (~b & q_q);
            // S=R=1 falls into the hold term, keeping the bit unchanged
            MODE_SR: q_next = (a & ~b) | (q_q & ~(a ^ b));
        endcase

        q_d       = en ? q_next : q_q;
        q_n_d     = ~q_d;
        toggled_d = q_d ^ q_q;

        sr_set = en && (mode == MODE_SR) && (|(a & b));
        if (sr_set) begin
            sr_err_d = 1'b1;
        end else if (err_clr) begin
            sr_err_d = 1'b0;
        end else begin
            sr_err_d = sr_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q       <= RESET_VAL;
            q_n_q     <= ~RESET_VAL;
            toggled_q <= '0;
            sr_err_q  <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_n_q     <= q_n_d;
            toggled_q <= toggled_d;
            sr_err_q  <= sr_err_d;
        end
    end

    assign q       = q_q;
    assign q_n     = q_n_q;
    assign toggled = toggled_q;
    assign sr_err  = sr_err_q;

endmodule

// File: tb/tb_multi_ff_bank.sv
// Scoreboard bench for multi_ff_bank: directed vectors with
// hand-computed results, then a randomised run against a bit-level model.
module tb_multi_ff_bank;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'h3C;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         err_clr;
    logic [W-1:0] q;
    logic [W-1:0] q_n;
    logic [W-1:0] toggled;
    logic         sr_err;

    multi_ff_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .a(a), .b(b), .err_clr(err_clr),
        .q(q), .q_n(q_n), .toggled(toggled), .sr_err(sr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] tog;
        logic         err;
        string        name;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_q;
    logic         m_err;

    // Reference model: explicit per-bit truth tables.
    task automatic model(input logic r, input logic e,
                         input logic [1:0] md,
                         input logic [W-1:0] ia,
                         input logic [W-1:0] ib,
                         input logic clr,
                         output logic [W-1:0] nq,
                         output logic [W-1:0] tg,
                         output logic ne);
        logic ill;
        ill = 1'b0;
        nq  = m_q;
        if (!r) begin
            nq = RV;
            tg = '0;
            ne = 1'b0;
        end else begin
            if (e) begin
                for (int i = 0; i < W; i++) begin
                    case (md)
                        2'd0: nq[i] = ia[i];
                        2'd1: nq[i] = ia[i] ? ~m_q[i] : m_q[i];
                        2'd2: case ({ia[i], ib[i]})
                            2'b00: nq[i] = m_q[i];
                            2'b10: nq[i] = 1'b1;
                            2'b01: nq[i] = 1'b0;
                            default: nq[i] = ~m_q[i];
                        endcase
                        default: case ({ia[i], ib[i]})
                            2'b00: nq[i] = m_q[i];
                            2'b10: nq[i] = 1'b1;
                            2'b01: nq[i] = 1'b0;
                            default: begin
                                nq[i] = m_q[i];
                                ill = 1'b1;
                            end
                        endcase
                    endcase
                end
            end
            tg = nq ^ m_q;
            if (ill)      ne = 1'b1;
            else if (clr) ne = 1'b0;
            else          ne = m_err;
        end
    endtask

    task automatic step(input logic r, input logic e,
                        input logic [1:0] md,
                        input logic [W-1:0] ia,
                        input logic [W-1:0] ib,
                        input logic clr,
                        input bit hand,
                        input logic [W-1:0] hq,
                        input logic [W-1:0] htg,
                        input logic her,
                        input string nm);
        logic [W-1:0] nq, tg;
        logic ne;
        exp_t x;
        @(negedge clk);
        rst_n = r; en = e; mode = md;
        a = ia; b = ib; err_clr = clr;
        model(r, e, md, ia, ib, clr, nq, tg, ne);
        m_q   = nq;
        m_err = ne;
        if (hand) begin
            x.q = hq; x.tog = htg; x.err = her;
        end else begin
            x.q = nq; x.tog = tg; x.err = ne;
        end
        x.name = nm;
        exp_q.push_back(x);
    endtask

    task automatic dstep(input logic r, input logic e,
                         input logic [1:0] md,
                         input logic [W-1:0] ia,
                         input logic [W-1:0] ib,
                         input logic clr,
                         input logic [W-1:0] hq,
                         input logic [W-1:0] htg,
                         input logic her,
                         input string nm);
        step(r, e, md, ia, ib, clr, 1'b1, hq, htg, her, nm);
    endtask

    task automatic report(input string nm, input string f,
                          input logic [W-1:0] act,
                          input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s.%s got %h expected %h",
                         nm, f, act, req);
        end
    endtask

    // Monitor: every edge presents a result, compare the oldest one.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                report(x.name, "q", q, x.q);
                report(x.name, "q_n", q_n, ~x.q);
                report(x.name, "toggled", toggled, x.tog);
                report(x.name, "sr_err", {7'd0, sr_err}, {7'd0, x.err});
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'b00;
        a = '0; b = '0; err_clr = 1'b0;
        m_q = RV; m_err = 1'b0;

        dstep(0, 1, 2'b00, 8'hFF, 8'h00, 0, 8'h3C, 8'h00, 0, "reset");
        dstep(1, 1, 2'b00, 8'hA5, 8'h00, 0, 8'hA5, 8'h99, 0, "d_load");
        dstep(1, 1, 2'b01, 8'h0F, 8'h00, 0, 8'hAA, 8'h0F, 0, "t_tog");
        for (int i = 0; i < 3; i++)
            dstep(1, 0, 2'b00, 8'h55, 8'h00, 0, 8'hAA, 8'h00, 0, "en_off");
        dstep(1, 1, 2'b10, 8'hF0, 8'h3C, 0, 8'hD2, 8'h78, 0, "jk");
        dstep(1, 1, 2'b11, 8'h81, 8'h01, 0, 8'hD2, 8'h00, 1, "sr_ill");
        dstep(1, 1, 2'b11, 8'h81, 8'h01, 1, 8'hD2, 8'h00, 1, "sr_set_wins");
        dstep(1, 1, 2'b11, 8'h00, 8'h00, 1, 8'hD2, 8'h00, 0, "sr_clr");
        dstep(1, 1, 2'b01, 8'hFF, 8'h00, 0, 8'h2D, 8'hFF, 0, "t_run1");
        dstep(1, 1, 2'b01, 8'hFF, 8'h00, 0, 8'hD2, 8'hFF, 0, "t_run2");
        dstep(0, 1, 2'b01, 8'hFF, 8'h00, 0, 8'h3C, 8'h00, 0, "mid_reset");
        dstep(1, 1, 2'b01, 8'hFF, 8'h00, 0, 8'hC3, 8'hFF, 0, "t_resume");
        dstep(1, 0, 2'b11, 8'hFF, 8'hFF, 0, 8'hC3, 8'h00, 0, "sr_en_off");
        dstep(1, 1, 2'b11, 8'h0C, 8'h42, 0, 8'h8D, 8'h4E, 0, "sr_legal");
        dstep(1, 1, 2'b11, 8'h10, 8'h11, 0, 8'h8C, 8'h01, 1, "sr_mixed");
        dstep(1, 0, 2'b00, 8'h00, 8'h00, 1, 8'h8C, 8'h00, 0, "clr_en_off");

        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(63) != 0),
                 ($urandom_range(3) != 0),
                 2'($urandom_range(3)),
                 8'($urandom), 8'($urandom),
                 ($urandom_range(3) == 0),
                 1'b0, '0, '0, 1'b0, "rand");
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain left %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
